// File: rtl/mccoy_sequencer_if.sv
// Instruction-memory handshake between the McCoy sequencer and its instruction source.
// The sequencer drives the request and address. The source answers with a valid byte.
interface mccoy_sequencer_if #(
  parameter int PC_W = 5
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_valid;
  logic [7:0]      imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_rdata
  );
endinterface

// File: rtl/mccoy_sequencer.sv
// Multi-cycle control FSM for the McCoy 8-bit CPU: fetch, decode, branch resolution,
// write-back strobes, retired-instruction counting and sticky halt/fault reporting.
module mccoy_sequencer #(
  parameter int PC_W          = 5,
  parameter int FETCH_TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  mccoy_sequencer_if.master   imem,
  output logic [2:0]          dec_opcode,
  input  logic                dec_bez,
  input  logic                dec_ja,
  input  logic                dec_writeReg,
  input  logic                dec_writex8,
  input  logic                x8_zero,
  output logic [7:0]          ir,
  output logic [PC_W-1:0]     pc,
  output logic                reg_we,
  output logic                x8_we,
  output logic [2:0]          state,
  output logic                halted,
  output logic                fault,
  output logic [7:0]          instr_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } fsm_t;

  localparam logic [7:0] WAIT_LAST = 8'(FETCH_TIMEOUT - 1);

  fsm_t       fsm;
  logic [7:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm         <= IDLE;
      pc          <= '0;
      ir          <= '0;
      instr_count <= '0;
      wait_cnt    <= '0;
      halted      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (run) fsm <= FETCH;
        end
        // The final wait cycle goes straight to HALT, so a stalled fetch spans exactly FETCH_TIMEOUT cycles
        FETCH: begin
          if (imem.imem_valid) begin
            ir       <= imem.imem_rdata;
            wait_cnt <= '0;
            fsm      <= DECODE;
          end else if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= '0;
            halted   <= 1'b1;
            fault    <= 1'b1;
            fsm      <= HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DECODE: begin
          if (ir[7:5] == 3'b111) begin
            halted <= 1'b1;
            fsm    <= HALT;
          end else begin
            fsm <= EXEC;
          end
        end
        EXEC: begin
          if (dec_ja || (dec_bez && x8_zero)) pc <= PC_W'(ir[4:0]);
          else                                 pc <= pc + PC_W'(1);
          if (dec_writeReg || dec_writex8) begin
            fsm <= WB;
          end else begin
            instr_count <= instr_count + 8'd1;
            fsm         <= run ? FETCH : IDLE;
          end
        end
        WB: begin
          instr_count <= instr_count + 8'd1;
          fsm         <= run ? FETCH : IDLE;
        end
        HALT: begin
          fsm <= HALT;
        end
        default: begin
          fsm <= IDLE;
        end
      endcase
    end
  end

  // Strobes and the fetch request are pure state decodes, so they can never leak outside their state
  assign imem.imem_req  = (fsm == FETCH);
  assign imem.imem_addr = pc;
  assign reg_we         = (fsm == WB) && dec_writeReg;
  assign x8_we          = (fsm == WB) && dec_writex8;
  assign dec_opcode     = ir[7:5];
  assign state          = fsm;

endmodule

// File: tb/tb_mccoy_sequencer.sv
// Directed bench for mccoy_sequencer: a tiny instruction ROM plus a stand-in opcode decoder
// (000 bez, 001 li, 010 ja, 011 nop, 110 sr, 111 halt).
module tb_mccoy_sequencer;

  localparam int PC_W = 5;

  logic            clk;
  logic            rst_n;
  logic            run;
  logic [2:0]      dec_opcode;
  logic            dec_bez;
  logic            dec_ja;
  logic            dec_writeReg;
  logic            dec_writex8;
  logic            x8_zero;
  logic [7:0]      ir;
  logic [PC_W-1:0] pc;
  logic            reg_we;
  logic            x8_we;
  logic [2:0]      state;
  logic            halted;
  logic            fault;
  logic [7:0]      instr_count;

  logic [7:0]      mem [32];
  logic            imem_en;
  int              checks;
  int              passed;

  mccoy_sequencer_if #(.PC_W(PC_W)) imem_bus ();

  mccoy_sequencer #(.PC_W(PC_W), .FETCH_TIMEOUT(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .imem         (imem_bus.master),
    .dec_opcode   (dec_opcode),
    .dec_bez      (dec_bez),
    .dec_ja       (dec_ja),
    .dec_writeReg (dec_writeReg),
    .dec_writex8  (dec_writex8),
    .x8_zero      (x8_zero),
    .ir           (ir),
    .pc           (pc),
    .reg_we       (reg_we),
    .x8_we        (x8_we),
    .state        (state),
    .halted       (halted),
    .fault        (fault),
    .instr_count  (instr_count)
  );

  assign imem_bus.imem_valid = imem_en && imem_bus.imem_req;
  assign imem_bus.imem_rdata = mem[imem_bus.imem_addr];
  assign dec_bez      = (dec_opcode == 3'b000);
  assign dec_writex8  = (dec_opcode == 3'b001);
  assign dec_ja       = (dec_opcode == 3'b010);
  assign dec_writeReg = (dec_opcode == 3'b110);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic apply_stimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  initial begin
    checks  = 0;
    passed  = 0;
    rst_n   = 1'b0;
    run     = 1'b1;
    x8_zero = 1'b1;
    imem_en = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = 8'h60;
    mem[0]  = 8'h20;
    mem[1]  = 8'h0C;
    mem[12] = 8'h0C;
    mem[13] = 8'h43;
    mem[3]  = 8'h5F;
    mem[31] = 8'h60;

    // Reset values and a writing instruction (li)
    #1;
    check_output("rst_state", 32'(state), 32'd0);
    check_output("rst_pc", 32'(pc), 32'd0);
    check_output("rst_ir", 32'(ir), 32'd0);
    check_output("rst_count", 32'(instr_count), 32'd0);
    check_output("rst_flags", {halted, fault, imem_bus.imem_req, reg_we, x8_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(1);
    check_output("li_fetch_state", 32'(state), 32'd1);
    check_output("li_fetch_req", 32'(imem_bus.imem_req), 32'd1);
    apply_stimulus(1);
    check_output("li_decode_state", 32'(state), 32'd2);
    check_output("li_ir", 32'(ir), 32'h20);
    check_output("li_opcode", 32'(dec_opcode), 32'd1);
    apply_stimulus(1);
    check_output("li_exec_state", 32'(state), 32'd3);
    check_output("li_exec_x8_we", 32'(x8_we), 32'd0);
    apply_stimulus(1);
    check_output("li_wb_state", 32'(state), 32'd4);
    check_output("li_wb_strobes", {reg_we, x8_we}, 32'b01);
    check_output("li_wb_pc", 32'(pc), 32'd1);
    apply_stimulus(1);
    check_output("li_retire_state", 32'(state), 32'd1);
    check_output("li_retire_count", 32'(instr_count), 32'd1);
    check_output("li_retire_x8_we", 32'(x8_we), 32'd0);

    // bez taken at pc 1, then not taken at pc 12
    apply_stimulus(2);
    check_output("bez_exec_strobes", {reg_we, x8_we}, 32'd0);
    apply_stimulus(1);
    check_output("bez_taken_pc", 32'(pc), 32'd12);
    check_output("bez_taken_state", 32'(state), 32'd1);
    check_output("bez_taken_count", 32'(instr_count), 32'd2);
    x8_zero = 1'b0;
    apply_stimulus(3);
    check_output("bez_fall_pc", 32'(pc), 32'd13);
    check_output("bez_fall_count", 32'(instr_count), 32'd3);

    // ja 3, ja 31 from pc 3, then a nop at 31 wraps pc to 0
    apply_stimulus(3);
    check_output("ja_to_3_pc", 32'(pc), 32'd3);
    apply_stimulus(3);
    check_output("ja_to_31_pc", 32'(pc), 32'd31);
    apply_stimulus(3);
    check_output("wrap_pc", 32'(pc), 32'd0);
    check_output("wrap_count", 32'(instr_count), 32'd6);
    check_output("wrap_state", 32'(state), 32'd1);

    // Fetch timeout: eight FETCH cycles without valid, then fault halt
    imem_en = 1'b0;
    apply_stimulus(7);
    check_output("timeout_wait_state", 32'(state), 32'd1);
    check_output("timeout_wait_halted", 32'(halted), 32'd0);
    apply_stimulus(1);
    check_output("timeout_state", 32'(state), 32'd5);
    check_output("timeout_flags", {halted, fault, imem_bus.imem_req}, 32'b110);
    check_output("timeout_count", 32'(instr_count), 32'd6);

    // Halt opcode after one nop: clean halt, count frozen, run ignored
    rst_n = 1'b0;
    #1;
    check_output("rst2_flags", {halted, fault, 3'(state)}, 32'd0);
    mem[0]  = 8'h60;
    mem[1]  = 8'hE0;
    imem_en = 1'b1;
    x8_zero = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(5);
    check_output("halt_pre_state", 32'(state), 32'd2);
    apply_stimulus(1);
    check_output("halt_state", 32'(state), 32'd5);
    check_output("halt_flags", {halted, fault}, 32'b10);
    check_output("halt_count", 32'(instr_count), 32'd1);
    check_output("halt_pc", 32'(pc), 32'd1);
    run = 1'b0;
    apply_stimulus(2);
    run = 1'b1;
    apply_stimulus(2);
    check_output("halt_sticky_state", 32'(state), 32'd5);
    check_output("halt_sticky_outs", {imem_bus.imem_req, reg_we, x8_we}, 32'd0);

    // sr with run dropped in EXEC, then reset asserted mid-EXEC
    rst_n = 1'b0;
    mem[0] = 8'hC3;
    mem[1] = 8'hC3;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(3);
    check_output("sr_exec_state", 32'(state), 32'd3);
    run = 1'b0;
    apply_stimulus(1);
    check_output("sr_wb_state", 32'(state), 32'd4);
    check_output("sr_wb_strobes", {reg_we, x8_we}, 32'b10);
    apply_stimulus(1);
    check_output("sr_idle_state", 32'(state), 32'd0);
    check_output("sr_idle_count", 32'(instr_count), 32'd1);
    check_output("sr_idle_strobes", {imem_bus.imem_req, reg_we, x8_we}, 32'd0);
    apply_stimulus(1);
    check_output("sr_idle_hold", 32'(state), 32'd0);
    run = 1'b1;
    apply_stimulus(3);
    check_output("sr2_exec_state", 32'(state), 32'd3);
    rst_n = 1'b0;
    #1;
    check_output("async_rst_state", 32'(state), 32'd0);
    check_output("async_rst_regs", {3'(pc), ir, instr_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
